// File: rtl/uart_rx_fifo_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding and default line timing.
package uart_rx_fifo_pkg;

  localparam int UART_CLK_FREQ_DEF = 32'd50_000_000;
  localparam int UART_BAUD_DEF     = 32'd9600;
  localparam int UART_DATA_BITS    = 32'd8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_IDLE = 3'd4
  } uart_state_e;

  // Bits arrive LSB first, so each new bit enters at the top of the byte.
  function automatic logic [7:0] shift_in_lsb_first(input logic [7:0] cur, input logic bit_in);
    return {bit_in, cur[7:1]};
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock byte FIFO with registered read data, registered flags and a drop-on-full overflow pulse.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty,
  output logic             full,
  output logic             overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic [CW-1:0]    count_nxt_s;
  logic [WIDTH-1:0] rd_data_r;
  logic             empty_r;
  logic             full_r;
  logic             overflow_r;
  logic             do_push_s;
  logic             do_pop_s;

  // Qualify requests against the current flags and compute next occupancy.
  always_comb begin
    do_push_s   = push & ~full_r;
    do_pop_s    = pop & ~empty_r;
    count_nxt_s = count_r;
    if (do_push_s && !do_pop_s) begin
      count_nxt_s = count_r + CW'(1);
    end else if (!do_push_s && do_pop_s) begin
      count_nxt_s = count_r - CW'(1);
    end else begin
      count_nxt_s = count_r;
    end
  end

  // Storage array; pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointers, occupancy, flags and the registered read port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      count_r    <= '0;
      rd_data_r  <= '0;
      empty_r    <= 1'b1;
      full_r     <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (do_pop_s) begin
        rd_ptr_r  <= rd_ptr_r + AW'(1);
        rd_data_r <= mem_r[rd_ptr_r];
      end
      count_r    <= count_nxt_s;
      empty_r    <= (count_nxt_s == CW'(0));
      full_r     <= (count_nxt_s == CW'(DEPTH));
      overflow_r <= push & full_r;
    end
  end

  assign pop_data = rd_data_r;
  assign empty    = empty_r;
  assign full     = full_r;
  assign overflow = overflow_r;

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with mid-bit sampling, frame-error detection and a byte FIFO on the output.
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int CLK_FREQ   = UART_CLK_FREQ_DEF,
  parameter int BAUD       = UART_BAUD_DEF,
  parameter int FIFO_DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_pin,
  input  logic       fifo_read_req,
  output logic [7:0] fifo_read_data,
  output logic       empty,
  output logic       full,
  output logic       frame_err,
  output logic       overflow
);

  localparam int BAUD_DIV = CLK_FREQ / BAUD;
  localparam int TW       = $clog2(BAUD_DIV);
  localparam logic [TW-1:0] HALF_M1 = TW'(BAUD_DIV / 2 - 1);
  localparam logic [TW-1:0] FULL_M1 = TW'(BAUD_DIV - 1);

  uart_state_e state_r;
  uart_state_e state_nxt_s;

  logic          sync1_r;
  logic          sync2_r;
  logic          rx_prev_r;
  logic          rx_s;
  logic          fall_s;
  logic [TW-1:0] timer_r;
  logic [2:0]    bit_idx_r;
  logic [7:0]    shift_r;
  logic          frame_err_r;
  logic          tick_half_s;
  logic          tick_full_s;
  logic          timer_clr_s;
  logic          bit_clr_s;
  logic          shift_en_s;
  logic          push_s;
  logic          ferr_s;

  assign rx_s        = sync2_r;
  assign fall_s      = rx_prev_r & ~rx_s;
  assign tick_half_s = (timer_r == HALF_M1);
  assign tick_full_s = (timer_r == FULL_M1);

  // Two-flop synchronizer plus one delayed copy for falling-edge detection; idles high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r   <= 1'b1;
      sync2_r   <= 1'b1;
      rx_prev_r <= 1'b1;
    end else begin
      sync1_r   <= rx_pin;
      sync2_r   <= sync1_r;
      rx_prev_r <= sync2_r;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= ST_IDLE;
    else        state_r <= state_nxt_s;
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (fall_s) state_nxt_s = ST_START;
        else        state_nxt_s = ST_IDLE;
      end
      ST_START: begin
        if (tick_half_s) state_nxt_s = rx_s ? ST_IDLE : ST_DATA;
        else             state_nxt_s = ST_START;
      end
      ST_DATA: begin
        if (tick_full_s && (bit_idx_r == 3'd7)) state_nxt_s = ST_STOP;
        else                                    state_nxt_s = ST_DATA;
      end
      ST_STOP: begin
        if (tick_full_s) state_nxt_s = rx_s ? ST_IDLE : ST_WAIT_IDLE;
        else             state_nxt_s = ST_STOP;
      end
      ST_WAIT_IDLE: begin
        if (rx_s) state_nxt_s = ST_IDLE;
        else      state_nxt_s = ST_WAIT_IDLE;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM outputs: timer control, bit shifting and the per-frame verdict.
  always_comb begin
    timer_clr_s = 1'b0;
    bit_clr_s   = 1'b0;
    shift_en_s  = 1'b0;
    push_s      = 1'b0;
    ferr_s      = 1'b0;
    case (state_r)
      ST_IDLE:      timer_clr_s = 1'b1;
      ST_START: begin
        timer_clr_s = tick_half_s;
        bit_clr_s   = 1'b1;
      end
      ST_DATA: begin
        timer_clr_s = tick_full_s;
        shift_en_s  = tick_full_s;
      end
      ST_STOP: begin
        timer_clr_s = tick_full_s;
        push_s      = tick_full_s & rx_s;
        ferr_s      = tick_full_s & ~rx_s;
      end
      ST_WAIT_IDLE: timer_clr_s = 1'b1;
      default:      timer_clr_s = 1'b1;
    endcase
  end

  // Bit timer, bit index and shift register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_r     <= '0;
      bit_idx_r   <= 3'd0;
      shift_r     <= 8'h00;
      frame_err_r <= 1'b0;
    end else begin
      timer_r <= timer_clr_s ? '0 : timer_r + TW'(1);
      if (bit_clr_s) begin
        bit_idx_r <= 3'd0;
      end else if (shift_en_s) begin
        bit_idx_r <= bit_idx_r + 3'd1;
      end
      if (shift_en_s) shift_r <= shift_in_lsb_first(shift_r, rx_s);
      frame_err_r <= ferr_s;
    end
  end

  assign frame_err = frame_err_r;

  uart_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_s),
    .push_data (shift_r),
    .pop       (fifo_read_req),
    .pop_data  (fifo_read_data),
    .empty     (empty),
    .full      (full),
    .overflow  (overflow)
  );

endmodule
